// File: rtl/writeback_commit_pkg.sv
// writeback_commit_pkg: shared state, entry and width definitions for the writeback commit stage
package writeback_commit_pkg;
  localparam int WB_XLEN        = 64;
  localparam int WB_CSR_ADDR_W  = 12;
  localparam int WB_REG_ADDR_W  = 5;
  localparam int WB_NUM_CSR_OPS = 3;
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wb_state_t;
  typedef struct packed {
    logic [WB_XLEN-1:0]                           pc;
    logic [WB_XLEN-1:0]                           result;
    logic [WB_REG_ADDR_W-1:0]                     dst;
    logic                                         rf_we;
    logic                                         stalled;
    logic [WB_NUM_CSR_OPS-1:0][WB_CSR_ADDR_W-1:0] csr_addr;
    logic [WB_NUM_CSR_OPS-1:0][WB_XLEN-1:0]       csr_data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_commit_prio_pick.sv
// wb_prio_pick: lowest-set-bit one-hot/index encoder with an at-most-one-bit-set flag
module wb_prio_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_is_last
);
  assign o_onehot  = i_req & (~i_req + N'(1));
  assign o_is_last = (i_req & (i_req - N'(1))) == '0;
  // scan downward so the lowest set bit wins
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[k]) o_idx = IW'(k);
  end
endmodule

// File: rtl/writeback_commit.sv
// writeback_commit: registered writeback stage draining CSR writes one per cycle before GPR commit; WB_INSTRET_EN adds a retired-instruction counter
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter int XLEN        = WB_XLEN,
  parameter int NUM_CSR_OPS = WB_NUM_CSR_OPS,
  parameter int REG_ADDR_W  = WB_REG_ADDR_W,
  parameter int CSR_ADDR_W  = WB_CSR_ADDR_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_stall,
  input  logic [XLEN-1:0]                   in_pc,
  input  logic [XLEN-1:0]                   in_result,
  input  logic [REG_ADDR_W-1:0]             in_dst,
  input  logic                              in_rf_we,
  input  logic [NUM_CSR_OPS-1:0]            in_csr_we,
  input  logic [NUM_CSR_OPS*CSR_ADDR_W-1:0] in_csr_addr,
  input  logic [NUM_CSR_OPS*XLEN-1:0]       in_csr_data,
  output logic                              rf_we,
  output logic [REG_ADDR_W-1:0]             rf_waddr,
  output logic [XLEN-1:0]                   rf_wdata,
  output logic                              csr_we,
  output logic [CSR_ADDR_W-1:0]             csr_waddr,
  output logic [XLEN-1:0]                   csr_wdata,
  output logic                              commit_valid,
  output logic [XLEN-1:0]                   commit_pc,
  output logic                              busy
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]                       instret
`endif
);
  localparam int IW = (NUM_CSR_OPS > 1) ? $clog2(NUM_CSR_OPS) : 1;
  wb_state_t              r_state;
  wb_entry_t              r_entry;
  wb_entry_t              w_entry;
  logic [NUM_CSR_OPS-1:0] r_pend;
  logic [NUM_CSR_OPS-1:0] w_onehot;
  logic [IW-1:0]          w_idx;
  logic                   w_is_last;
  logic                   w_active;
  logic                   w_last;
  logic                   w_accept;
  wb_prio_pick #(.N(NUM_CSR_OPS), .IW(IW)) u_pick (
    .i_req    (r_pend),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_is_last(w_is_last)
  );
  // outputs are held quiet while reset is asserted, so a drain cut by reset writes nothing more
  assign w_active = reset & (r_state == ACTIVE);
  assign w_last   = w_active & w_is_last;
  assign in_ready = reset & (~w_active | w_last);
  assign w_accept = in_valid & in_ready;
  assign busy     = w_active;
  // squash writes of bubbles and never target x0
  always_comb begin
    w_entry          = '0;
    w_entry.pc       = in_pc;
    w_entry.result   = in_result;
    w_entry.dst      = in_dst;
    w_entry.rf_we    = in_rf_we & ~in_stall & (in_dst != '0);
    w_entry.stalled  = in_stall;
    w_entry.csr_addr = in_csr_addr;
    w_entry.csr_data = in_csr_data;
  end
  // port drive: CSR slot picked by lowest pending bit, GPR and retire only on the last cycle
  always_comb begin
    csr_we       = w_active & (r_pend != '0);
    csr_waddr    = csr_we ? r_entry.csr_addr[w_idx] : '0;
    csr_wdata    = csr_we ? r_entry.csr_data[w_idx] : '0;
    rf_we        = w_last & r_entry.rf_we;
    rf_waddr     = rf_we ? r_entry.dst : '0;
    rf_wdata     = rf_we ? r_entry.result : '0;
    commit_valid = w_last & ~r_entry.stalled;
    commit_pc    = commit_valid ? r_entry.pc : '0;
  end
  // state, entry capture and per-cycle retirement of the pending CSR slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_entry <= '0;
      r_pend  <= '0;
    end else if (w_accept) begin
      r_state <= ACTIVE;
      r_entry <= w_entry;
      r_pend  <= in_csr_we & {NUM_CSR_OPS{~in_stall}};
    end else begin
      if (w_last) r_state <= IDLE;
      r_pend <= r_pend & ~w_onehot;
    end
  end
`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;
  assign instret = r_instret;
  // count every retired non-bubble instruction
  always_ff @(posedge clk) begin
    if (!reset) r_instret <= '0;
    else if (commit_valid) r_instret <= r_instret + 64'd1;
  end
`endif
endmodule

// File: tb/tb_writeback_commit.sv
// tb_writeback_commit: directed plus random checks of writeback_commit against a per-cycle expected-output queue
module tb_writeback_commit;
  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_stall;
  logic [63:0]   in_pc;
  logic [63:0]   in_result;
  logic [4:0]    in_dst;
  logic          in_rf_we;
  logic [2:0]    in_csr_we;
  logic [35:0]   in_csr_addr;
  logic [191:0]  in_csr_data;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          csr_we;
  logic [11:0]   csr_waddr;
  logic [63:0]   csr_wdata;
  logic          commit_valid;
  logic [63:0]   commit_pc;
  logic          busy;
`ifdef WB_INSTRET_EN
  logic [63:0]   instret;
  logic [63:0]   base;
`endif
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic        cwe;
    logic [11:0] ca;
    logic [63:0] cd;
    logic        rwe;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        cv;
    logic [63:0] pc;
  } rec_t;
  rec_t        q[$];
  logic [63:0] inst_m = '0;

  writeback_commit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_stall(in_stall),
    .in_pc(in_pc), .in_result(in_result), .in_dst(in_dst), .in_rf_we(in_rf_we),
    .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr), .in_csr_data(in_csr_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .busy(busy)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_entry();
    int   ks[$];
    int   n;
    rec_t r;
    for (int k = 0; k < 3; k++)
      if (in_csr_we[k] && !in_stall) ks.push_back(k);
    n = (ks.size() == 0) ? 1 : ks.size();
    for (int i = 0; i < n; i++) begin
      r = '{default: '0};
      if (i < ks.size()) begin
        r.cwe = 1'b1;
        r.ca  = in_csr_addr[ks[i]*12 +: 12];
        r.cd  = in_csr_data[ks[i]*64 +: 64];
      end
      if (i == n - 1) begin
        r.rwe = in_rf_we && !in_stall && in_dst != 5'd0;
        r.ra  = r.rwe ? in_dst : 5'd0;
        r.rd  = r.rwe ? in_result : 64'd0;
        r.cv  = !in_stall;
        r.pc  = r.cv ? in_pc : 64'd0;
      end
      q.push_back(r);
    end
  endtask

  task automatic cycle();
    rec_t e;
    logic er;
    logic acc;
    @(negedge clk);
    e = '{default: '0};
    if (reset && q.size() > 0) e = q[0];
    er = reset && q.size() <= 1;
    chk("in_ready", 128'(in_ready), 128'(er));
    chk("busy", 128'(busy), 128'(reset && q.size() > 0));
    chk("csr_port", {csr_we, csr_waddr, csr_wdata}, {e.cwe, e.ca, e.cd});
    chk("rf_port", {rf_we, rf_waddr, rf_wdata}, {e.rwe, e.ra, e.rd});
    chk("commit", {commit_valid, commit_pc}, {e.cv, e.pc});
`ifdef WB_INSTRET_EN
    chk("instret", 128'(instret), 128'(inst_m));
`endif
    acc = in_valid && er;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      inst_m = '0;
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.cv) inst_m++;
      end
      if (acc) push_entry();
    end
    #1;
  endtask

  task automatic randomize_inputs();
    in_valid    = $urandom_range(0, 3) != 0;
    in_stall    = $urandom_range(0, 4) == 0;
    in_pc       = {$urandom, $urandom};
    in_result   = {$urandom, $urandom};
    in_dst      = 5'($urandom_range(0, 31));
    in_rf_we    = 1'($urandom);
    in_csr_we   = 3'($urandom);
    in_csr_addr = {12'($urandom), 12'($urandom), 12'($urandom)};
    in_csr_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_stall = 1'b0; in_pc = '0; in_result = '0;
    in_dst = '0; in_rf_we = 1'b0; in_csr_we = '0; in_csr_addr = '0; in_csr_data = '0;
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    // single entry without CSR writes commits the next cycle
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_result = 64'h55; in_dst = 5'd5; in_rf_we = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    // two CSR writes in slots 0 and 2
    in_valid = 1'b1; in_csr_we = 3'b101;
    in_csr_addr = {12'h341, 12'h000, 12'h300};
    in_csr_data = {64'hB, 64'h0, 64'hA};
    cycle();
    in_valid = 1'b0;
    cycle(); cycle(); cycle();
    // same entry as a bubble
    in_valid = 1'b1; in_stall = 1'b1;
    cycle();
    in_valid = 1'b0; in_stall = 1'b0;
    cycle(); cycle();
    // four back-to-back single-cycle entries
    in_csr_we = 3'b000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'h1000 + 64'(i * 4); in_dst = 5'(i + 1);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    // reset cuts a three-write drain after its first write
    in_valid = 1'b1; in_csr_we = 3'b111;
    in_csr_addr = {12'h342, 12'h341, 12'h300};
    in_csr_data = {64'h3, 64'h2, 64'h1};
    cycle();
    in_valid = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle(); cycle();
    // ten entries, two of them bubbles
`ifdef WB_INSTRET_EN
    base = instret;
`endif
    in_csr_we = 3'b000;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_stall = (i == 3) || (i == 7); in_pc = 64'h2000 + 64'(i * 4);
      cycle();
    end
    in_valid = 1'b0; in_stall = 1'b0;
    cycle();
`ifdef WB_INSTRET_EN
    chk("instret_delta", 128'(instret - base), 128'd8);
`endif
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      reset = $urandom_range(0, 49) != 0;
      cycle();
    end
    reset = 1'b1; in_valid = 1'b0;
    cycle(); cycle(); cycle(); cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Registered, parametrised successor to the combinational writeback stage.
- Accepts one memory-stage result per handshake and holds it in a commit register.
- Retires its CSR writes one per cycle through a single CSR-file write port, lowest index first, then commits the GPR write and the retire pulse.
- Sits between the memory stage and the register file / CSR file. Back-pressures memory while CSR writes drain.

Parameters:
- XLEN, 64, datapath width of pc, result and CSR data.
- NUM_CSR_OPS, 3, CSR write slots per instruction (>=1).
- REG_ADDR_W, 5, GPR index width.
- CSR_ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low (0 = reset); sampled on rising clk.
- in_valid  in  1  memory-stage entry valid.
- in_ready  out  1  entry accepted this cycle when in_valid & in_ready.
- in_stall  in  1  entry is a bubble; its CSR and GPR writes are squashed.
- in_pc  in  XLEN  instruction pc.
- in_result  in  XLEN  GPR write data.
- in_dst  in  REG_ADDR_W  GPR destination.
- in_rf_we  in  1  GPR write requested.
- in_csr_we  in  NUM_CSR_OPS  per-slot CSR write request.
- in_csr_addr  in  NUM_CSR_OPS*CSR_ADDR_W  slot i at bits [i*CSR_ADDR_W +: CSR_ADDR_W].
- in_csr_data  in  NUM_CSR_OPS*XLEN  slot i at bits [i*XLEN +: XLEN].
- rf_we / rf_waddr / rf_wdata  out  1 / REG_ADDR_W / XLEN  GPR write port.
- csr_we / csr_waddr / csr_wdata  out  1 / CSR_ADDR_W / XLEN  CSR write port.
- commit_valid  out  1  one-cycle retire pulse.
- commit_pc  out  XLEN  pc of the retiring entry.
- busy  out  1  entry held (state != IDLE).

Behaviour:
- States: IDLE (no entry) and ACTIVE (entry held).
- Capture on accept:
  - entry register <= inputs;
  - pend <= in_csr_we & {NUM_CSR_OPS{~in_stall}};
  - rf_pend <= in_rf_we & ~in_stall & (in_dst != 0).
- In ACTIVE, each cycle:
  - If pend != 0: drive the CSR write for the lowest set bit k (csr_we=1, addr/data of slot k), then clear bit k.
  - The last cycle is the cycle where pend has at most one bit set. In that cycle also drive rf_we=rf_pend and commit_valid=~stalled_entry, and set commit_pc.
  - An entry with pend == 0 commits in its first ACTIVE cycle.
- Latency:
  - An entry with m CSR writes commits max(m,1) cycles after acceptance.
  - The GPR write and commit_valid appear in the same cycle as the final CSR write.
- in_ready = (state == IDLE) | last cycle. This gives back-to-back accept with no bubble cycle.
- Transitions:
  - IDLE -> ACTIVE on accept.
  - ACTIVE -> ACTIVE on a last cycle with a new accept, or when not the last cycle.
  - ACTIVE -> IDLE on a last cycle without a new accept.
- Squashed (bubble) entry: occupies one cycle; produces no csr_we, no rf_we and no commit_valid.
- Outputs are combinational from the entry register and pend; when not writing they are 0: rf_we, csr_we, commit_valid = 0, data/addr = 0.
- Reset (also when asserted mid-drain): state=IDLE, pend=0, entry register=0, all outputs 0, in_ready=1 in the cycle after reset deasserts. Any remaining CSR writes are discarded.
- Writes to x0 are never issued.

Optional Feature:
- Macro: WB_INSTRET_EN.
- When defined: adds output instret (64-bit). It resets to 0 and increments by 1 on every commit_valid cycle, wrapping at 2^64.
- When undefined: the port and counter are absent.

Decomposition:
- Shared package (common) holds:
  - a wb_state_t enum {IDLE, ACTIVE};
  - a wb_entry_t struct (pc, result, dst, rf_we, stalled, csr addr/data arrays);
  - XLEN and CSR_ADDR_W constants.
- One sub-module, wb_prio_pick: NUM_CSR_OPS-bit lowest-set-bit one-hot/index encoder, plus an is_last flag (popcount <= 1).

Test Plan:
- Entry pc=0x8000_0000, result=0x55, dst=5, rf_we=1, csr_we=000 -> next cycle rf_we=1 waddr=5 wdata=0x55, commit_valid=1, commit_pc=0x8000_0000; in_ready stays 1.
- csr_we=101, addr0=0x300/data0=0xA, addr2=0x341/data2=0xB:
  - cycle1: csr 0x300<-0xA, in_ready=0;
  - cycle2: csr 0x341<-0xB with rf_we and commit_valid, in_ready=1.
- Same entry with in_stall=1 -> one busy cycle; no csr_we, no rf_we, no commit_valid.
- Back-to-back single-cycle entries on 4 consecutive cycles -> 4 consecutive commit_valid pulses; in_ready never 0.
- reset=0 asserted on cycle 2 of a csr_we=111 drain -> slots 1 and 2 are never written; busy=0 and in_ready=1 after release.
- WB_INSTRET_EN: 10 commits including 2 bubbles -> instret=8.
